// File: rtl/mem_buf_pkg.sv
// Shared types and header-field layout for the 64-bit memory FIFO buffer.
package mem_buf_pkg;
  typedef enum logic {
    S_HDR = 1'b0,
    S_PAY = 1'b1
  } drain_state_t;

  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_W   = 8;
endpackage

// File: rtl/tx_out_reg.sv
// One-stage valid/ready output register carrying a beat with start/end markers.
module tx_out_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_sop,
  input  logic             load_eop,
  input  logic             tx_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  output logic             tx_sop,
  output logic             tx_eop
);
  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;
  logic             sop_reg;
  logic             eop_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      sop_reg   <= 1'b0;
      eop_reg   <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      valid_reg <= 1'b1;
      sop_reg   <= load_sop;
      eop_reg   <= load_eop;
    end else if (tx_ready) begin
      // Beat consumed with nothing to replace it; payload fields may go stale.
      valid_reg <= 1'b0;
    end
  end

  assign tx_data  = data_reg;
  assign tx_valid = valid_reg;
  assign tx_sop   = sop_reg;
  assign tx_eop   = eop_reg;
endmodule

// File: rtl/mem_fifo_drain.sv
// Pops show-ahead FIFO words, frames them as header + len payload beats, and
// forwards them on a registered valid/ready stream with frame count and underrun flag.
module mem_fifo_drain
  import mem_buf_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LEN_W = HDR_LEN_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rd,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             underrun
);
  drain_state_t     state_reg;
  logic [LEN_W-1:0] rem_reg;
  logic [CNT_W-1:0] frame_cnt_reg;
  logic             underrun_reg;
  logic [LEN_W-1:0] hdr_len;
  logic             out_free;
  logic             load;
  logic             sop_next;
  logic             eop_next;

  assign hdr_len  = fifo_rdata[HDR_LEN_LSB +: LEN_W];
  assign out_free = ~tx_valid | tx_ready;
  // Gating with reset keeps the pop strobe quiet while the FIFO is also being cleared.
  assign load     = ~reset & ~fifo_empty & out_free;
  assign fifo_rd  = load;

  always_comb begin
    sop_next = (state_reg == S_HDR);
    eop_next = sop_next ? (hdr_len == '0) : (rem_reg == LEN_W'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_HDR;
      rem_reg       <= '0;
      frame_cnt_reg <= '0;
      underrun_reg  <= 1'b0;
    end else begin
      if (load) begin
        case (state_reg)
          S_HDR: begin
            if (hdr_len != '0) begin
              rem_reg   <= hdr_len;
              state_reg <= S_PAY;
            end
          end
          S_PAY: begin
            rem_reg <= rem_reg - LEN_W'(1);
            if (rem_reg == LEN_W'(1)) state_reg <= S_HDR;
          end
          default: state_reg <= S_HDR;
        endcase
      end
      if (tx_valid & tx_ready & tx_eop) frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
      // Starved mid-frame while the output could have taken a payload word.
      if ((state_reg == S_PAY) & fifo_empty & out_free) underrun_reg <= 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign underrun  = underrun_reg;

  tx_out_reg #(.WIDTH(WIDTH)) u_tx_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (fifo_rdata),
    .load_sop  (sop_next),
    .load_eop  (eop_next),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_sop    (tx_sop),
    .tx_eop    (tx_eop)
  );
endmodule
